// File: rtl/dispatch_addr_form.sv
// ---------------------------------------------------------------------------
// dispatch_addr_form
//
// Purpose:
//   Dispatch-address formation stage sitting behind the dispatch-mask PROM
//   (32x8, registered output, one cycle of latency). A request supplies:
//     - a source word,
//     - a right-rotate amount,
//     - a field width,
//     - a dispatch base.
//   The field width is driven to the PROM as its address. The returned mask
//   is applied to the low byte of the rotated source word. The result is
//   ORed into the base to form the dispatch-memory address.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset_n    asynchronous active-low reset
//   req_valid  request present
//   req_ready  block can accept a request (IDLE only)
//   req_data   source word
//   req_pos    right-rotate amount, 0..DATA_W-1
//   req_len    field width in bits, 0..7
//   req_base   dispatch base address
//   mask_addr  PROM address, {2'b00, latched len}
//   mask_q     PROM data, valid the cycle after mask_addr is sampled
//   disp_valid disp_addr valid
//   disp_ready consumer accepts disp_addr
//   disp_addr  formed dispatch address
//   flush      synchronous abort back to IDLE
// ---------------------------------------------------------------------------
module dispatch_addr_form #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [DATA_W-1:0]         req_data,
  input  logic [$clog2(DATA_W)-1:0] req_pos,
  input  logic [2:0]                req_len,
  input  logic [ADDR_W-1:0]         req_base,
  output logic [4:0]                mask_addr,
  input  logic [7:0]                mask_q,
  output logic                      disp_valid,
  input  logic                      disp_ready,
  output logic [ADDR_W-1:0]         disp_addr,
  input  logic                      flush
);

  localparam int POS_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FORM,
    DONE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   data_reg;
  logic [POS_W-1:0]    pos_reg;
  logic [ADDR_W-1:0]   base_reg;

  logic [7:0]          rot_lo;
  logic [7:0]          field;
  logic [ADDR_W-1:0]   field_ext;

  // Only the low byte of the rotated word is ever consumed.
  // Each output bit i is source bit (i + pos) mod DATA_W. Because DATA_W is
  // a power of two, the POS_W-bit index addition wraps naturally.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      logic [POS_W-1:0] idx;
      assign idx = pos_reg + POS_W'(gi);
      assign rot_lo[gi] = data_reg[idx];
    end
  endgenerate

  // A len=7 mask is 7f, so rot bit 7 is always masked off.
  assign field = rot_lo & mask_q;

  always_comb begin
    field_ext      = '0;
    field_ext[7:0] = field;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      disp_valid <= 1'b0;
      disp_addr  <= '0;
      mask_addr  <= '0;
      data_reg   <= '0;
      pos_reg    <= '0;
      base_reg   <= '0;
    end else if (flush) begin
      // Abort from any state. disp_addr and mask_addr keep their values.
      // A request presented in the same cycle is dropped.
      state      <= IDLE;
      req_ready  <= 1'b1;
      disp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            data_reg  <= req_data;
            pos_reg   <= req_pos;
            base_reg  <= req_base;
            mask_addr <= {2'b00, req_len};
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          // The PROM samples mask_addr on this edge.
          // mask_q becomes valid in FORM.
          state <= FORM;
        end
        FORM: begin
          disp_addr  <= base_reg | field_ext;
          disp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (disp_ready) begin
            disp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          disp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_addr_form.sv
module tb_dispatch_addr_form;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [4:0]  req_pos;
  logic [2:0]  req_len;
  logic [10:0] req_base;
  logic [4:0]  mask_addr;
  logic [7:0]  mask_q;
  logic        disp_valid;
  logic        disp_ready;
  logic [10:0] disp_addr;
  logic        flush;

  int checks = 0;
  int errors = 0;
  logic [10:0] sb[$];
  logic [7:0]  rom[32];

  always #5 clk = ~clk;

  dispatch_addr_form #(.DATA_W(32), .ADDR_W(11)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_pos(req_pos), .req_len(req_len), .req_base(req_base),
    .mask_addr(mask_addr), .mask_q(mask_q),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_addr(disp_addr),
    .flush(flush)
  );

  // Dispatch-mask PROM model: registered output, one cycle of latency.
  // Entries 8..31 hold ff so any stray use would corrupt results.
  initial begin
    for (int i = 0; i < 32; i++) begin
      rom[i] = 8'hff;
    end
    for (int i = 0; i < 8; i++) begin
      rom[i] = 8'((9'd1 << i) - 9'd1);
    end
  end
  always @(posedge clk) mask_q <= rom[mask_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] model(input logic [31:0] d, input int p,
                                        input int l, input logic [10:0] b);
    logic [31:0] r;
    logic [7:0]  m;
    r = d;
    for (int i = 0; i < p; i++) begin
      r = {r[0], r[31:1]};
    end
    m = 8'h00;
    for (int i = 0; i < l; i++) begin
      m[i] = 1'b1;
    end
    return b | {3'b000, r[7:0] & m};
  endfunction

  // Scoreboard: compare on the cycle before the accepting edge.
  always @(negedge clk) begin
    if (reset_n && disp_valid && disp_ready && !flush) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'(disp_addr), 32'hffff_ffff);
      end else begin
        logic [10:0] e;
        e = sb.pop_front();
        check("disp_addr", 32'(disp_addr), 32'(e));
        $display("txn disp_addr=%03h expected=%03h", disp_addr, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_req(input logic [31:0] d, input logic [4:0] p, input logic [2:0] l,
                            input logic [10:0] b, input bit expect_out);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_data  = d;
    req_pos   = p;
    req_len   = l;
    req_base  = b;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    check("accept_wait", 32'(req_ready), 32'd1);
    if (expect_out) sb.push_back(model(d, int'(p), int'(l), b));
    step();
    req_valid = 1'b0;
    check("mask_addr", 32'(mask_addr), 32'(l));
    check("req_ready_busy", 32'(req_ready), 32'd0);
  endtask

  task automatic complete_req(input int stall);
    logic [10:0] a;
    step();
    check("dv_n1", 32'(disp_valid), 32'd0);
    step();
    check("dv_n2", 32'(disp_valid), 32'd1);
    a = disp_addr;
    for (int i = 0; i < stall; i++) begin
      disp_ready = 1'b0;
      step();
      check("bp_addr", 32'(disp_addr), 32'(a));
      check("bp_valid", 32'(disp_valid), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    disp_ready = 1'b1;
    step();
    disp_ready = 1'b0;
    check("post_hs_valid", 32'(disp_valid), 32'd0);
    check("post_hs_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] held;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_data   = '0;
    req_pos    = '0;
    req_len    = '0;
    req_base   = '0;
    disp_ready = 1'b0;
    flush      = 1'b0;
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_disp_addr", 32'(disp_addr), 32'd0);
    check("rst_mask_addr", 32'(mask_addr), 32'd0);
    reset_n = 1'b1;
    step();

    // Directed extraction and boundary cases
    accept_req(32'h0000_00A5, 5'd0, 3'd4, 11'h400, 1'b1);
    complete_req(0);
    accept_req(32'h0000_0001, 5'd31, 3'd2, 11'h000, 1'b1);
    complete_req(0);
    accept_req(32'h8000_0000, 5'd31, 3'd1, 11'h000, 1'b1);
    complete_req(0);
    accept_req(32'hFFFF_FFFF, 5'd0, 3'd0, 11'h123, 1'b1);
    complete_req(0);
    accept_req(32'hFFFF_FFFF, 5'd0, 3'd7, 11'h000, 1'b1);
    complete_req(0);
    accept_req(32'h0000_0070, 5'd0, 3'd3, 11'h00F, 1'b1);
    complete_req(0);

    // Backpressure with the next request held valid throughout
    accept_req(32'h0000_3C00, 5'd8, 3'd6, 11'h200, 1'b1);
    req_valid = 1'b1;
    req_data  = 32'h1234_5678;
    req_pos   = 5'd4;
    req_len   = 3'd5;
    req_base  = 11'h040;
    complete_req(5);
    accept_req(32'h1234_5678, 5'd4, 3'd5, 11'h040, 1'b1);
    complete_req(0);

    // Flush in LOOKUP: no output and back to IDLE
    accept_req(32'h0000_00FF, 5'd0, 3'd6, 11'h000, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_lk_ready", 32'(req_ready), 32'd1);
    check("flush_lk_maddr", 32'(mask_addr), 32'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_lk_novalid", 32'(disp_valid), 32'd0);
    end

    // Flush in DONE with a simultaneous request that must be ignored
    accept_req(32'h0000_0055, 5'd0, 3'd7, 11'h100, 1'b0);
    step();
    step();
    check("flush_dn_valid", 32'(disp_valid), 32'd1);
    held = disp_addr;
    flush     = 1'b1;
    req_valid = 1'b1;
    req_data  = 32'h0000_00AA;
    req_pos   = 5'd1;
    req_len   = 3'd3;
    req_base  = 11'h010;
    step();
    flush = 1'b0;
    check("flush_dn_drop", 32'(disp_valid), 32'd0);
    check("flush_dn_ready", 32'(req_ready), 32'd1);
    check("flush_dn_maddr", 32'(mask_addr), 32'd7);
    check("flush_dn_addr", 32'(disp_addr), 32'(held));
    accept_req(32'h0000_00AA, 5'd1, 3'd3, 11'h010, 1'b1);
    complete_req(1);

    // Reset while in FORM: asynchronous clear, then normal operation
    accept_req(32'hDEAD_BEEF, 5'd12, 3'd5, 11'h7F0, 1'b0);
    step();
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(disp_valid), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd1);
    check("arst_addr", 32'(disp_addr), 32'd0);
    check("arst_maddr", 32'(mask_addr), 32'd0);
    step();
    reset_n = 1'b1;
    accept_req(32'hCAFE_F00D, 5'd20, 3'd6, 11'h300, 1'b1);
    complete_req(0);

    // Random requests
    for (int k = 0; k < 10; k++) begin
      accept_req($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                 11'($urandom_range(0, 2047)), 1'b1);
      complete_req(int'($urandom_range(0, 2)));
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
